// File: rtl/mc97_pcm_wb_if.sv
// Register-bus bundle for the PCM FIFO block: 4-bit word address, 32-bit data,
// single-cycle cyc/ack handshake.
interface mc97_pcm_wb_if;
   logic [3:0]  wb_addr;
   logic [31:0] wb_wdata;
   logic [31:0] wb_rdata;
   logic        wb_we;
   logic        wb_cyc;
   logic        wb_ack;

   modport master (
      output wb_addr,
      output wb_wdata,
      output wb_we,
      output wb_cyc,
      input  wb_rdata,
      input  wb_ack
   );

   modport slave (
      input  wb_addr,
      input  wb_wdata,
      input  wb_we,
      input  wb_cyc,
      output wb_rdata,
      output wb_ack
   );
endinterface

// File: rtl/mc97_pcm_wb.sv
// Multi-channel PCM capture/playback FIFOs behind a small register bus.
// Each channel has an input (capture) FIFO and an output (playback) FIFO.
module mc97_pcm_wb #(
   parameter int N_CH    = 2,
   parameter int FIFO_AW = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   mc97_pcm_wb_if.slave         wb,
   input  logic [16*N_CH-1:0]   pcm_in_data,
   input  logic [N_CH-1:0]      pcm_in_stb,
   output logic [16*N_CH-1:0]   pcm_out_data,
   input  logic [N_CH-1:0]      pcm_out_ack,
   output logic                 irq
);
   localparam int DEPTH = 1 << FIFO_AW;
   localparam int LW    = FIFO_AW + 1;

   logic        ack_reg;
   logic [31:0] rdata_reg;
   logic        rd_pop_reg;
   logic        irq_reg;

   logic [1:0]  bus_ch;
   logic [1:0]  bus_reg;
   logic        bus_req;
   logic        bus_eff;
   logic [31:0] wd;

   logic [31:0] ch_rdata [4];
   logic [3:0]  ch_in_empty;
   logic [3:0]  ch_src;

   assign bus_ch  = wb.wb_addr[3:2];
   assign bus_reg = wb.wb_addr[1:0];
   assign wd      = wb.wb_wdata;
   // Request cycle computes read data; all side effects land at the end of the ack cycle.
   assign bus_req = wb.wb_cyc & ~ack_reg;
   assign bus_eff = wb.wb_cyc & ack_reg;

   logic unused_wdata;
   assign unused_wdata = ^{wd[29:28], wd[25], wd[13:12], wd[9]};

   always_ff @(posedge clk) begin
      if (rst) begin
         ack_reg    <= 1'b0;
         rdata_reg  <= 32'h0;
         rd_pop_reg <= 1'b0;
         irq_reg    <= 1'b0;
      end else begin
         ack_reg    <= bus_req;
         rdata_reg  <= (bus_req & ~wb.wb_we) ? ch_rdata[bus_ch] : 32'h0;
         // Pop only a word that was actually returned to the bus.
         rd_pop_reg <= bus_req & ~wb.wb_we & (bus_reg == 2'd2) & ~ch_in_empty[bus_ch];
         irq_reg    <= |ch_src;
      end
   end

   assign wb.wb_ack  = ack_reg;
   assign wb.wb_rdata = rdata_reg;
   assign irq        = irq_reg;

   for (genvar gi = 0; gi < 4; gi++) begin : g_slot
      if (gi < N_CH) begin : g_ch
         logic [15:0]        in_mem  [DEPTH];
         logic [15:0]        out_mem [DEPTH];
         logic [FIFO_AW-1:0] in_wp_reg, in_rp_reg, out_wp_reg, out_rp_reg;
         logic [LW-1:0]      in_lvl_reg, out_lvl_reg;
         logic               in_ena_reg, in_ie_reg, in_ovr_reg;
         logic               out_ena_reg, out_ie_reg, out_und_reg;
         logic [8:0]         in_thr_reg, out_thr_reg;

         logic sel, wr_csr, wr_thr, rd_in, wr_out;
         logic in_full, in_empty, out_full, out_empty;
         logic in_push_req, in_push, in_pop, in_flush, ovr_set;
         logic out_push, out_pop_req, out_pop, out_flush, und_set;
         logic [8:0]  in_lvl9, out_lvl9;
         logic [15:0] in_head, out_head;

         assign sel    = bus_eff & (bus_ch == 2'(gi));
         assign wr_csr = sel &  wb.wb_we & (bus_reg == 2'd0);
         assign wr_thr = sel &  wb.wb_we & (bus_reg == 2'd1);
         assign rd_in  = sel & ~wb.wb_we & (bus_reg == 2'd2) & rd_pop_reg;
         assign wr_out = sel &  wb.wb_we & (bus_reg == 2'd3);

         assign in_full   = (in_lvl_reg  == LW'(DEPTH));
         assign in_empty  = (in_lvl_reg  == '0);
         assign out_full  = (out_lvl_reg == LW'(DEPTH));
         assign out_empty = (out_lvl_reg == '0);

         assign in_push_req = pcm_in_stb[gi] & in_ena_reg;
         assign in_push     = in_push_req & ~in_full;
         assign ovr_set     = in_push_req &  in_full;
         assign in_pop      = rd_in & ~in_empty;
         assign in_flush    = wr_csr & wd[30];

         assign out_push    = wr_out & ~out_full;
         assign out_pop_req = pcm_out_ack[gi] & out_ena_reg;
         assign out_pop     = out_pop_req & ~out_empty;
         assign und_set     = out_pop_req &  out_empty;
         assign out_flush   = wr_csr & wd[14];

         // Heads are read asynchronously: playback data is combinational from FIFO state.
         assign in_head  = in_mem[in_rp_reg];
         assign out_head = out_mem[out_rp_reg];

         always_ff @(posedge clk) begin
            if (in_push)
               in_mem[in_wp_reg] <= pcm_in_data[16*gi +: 16];
            if (out_push)
               out_mem[out_wp_reg] <= wd[15:0];
         end

         always_ff @(posedge clk) begin
            if (rst || in_flush) begin
               in_wp_reg  <= '0;
               in_rp_reg  <= '0;
               in_lvl_reg <= '0;
            end else begin
               if (in_push) in_wp_reg <= in_wp_reg + 1'b1;
               if (in_pop)  in_rp_reg <= in_rp_reg + 1'b1;
               in_lvl_reg <= in_lvl_reg + LW'(in_push) - LW'(in_pop);
            end
         end

         always_ff @(posedge clk) begin
            if (rst || out_flush) begin
               out_wp_reg  <= '0;
               out_rp_reg  <= '0;
               out_lvl_reg <= '0;
            end else begin
               if (out_push) out_wp_reg <= out_wp_reg + 1'b1;
               if (out_pop)  out_rp_reg <= out_rp_reg + 1'b1;
               out_lvl_reg <= out_lvl_reg + LW'(out_push) - LW'(out_pop);
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               in_ena_reg  <= 1'b0;
               in_ie_reg   <= 1'b0;
               in_ovr_reg  <= 1'b0;
               out_ena_reg <= 1'b0;
               out_ie_reg  <= 1'b0;
               out_und_reg <= 1'b0;
               in_thr_reg  <= 9'(DEPTH / 2);
               out_thr_reg <= 9'(DEPTH / 2);
            end else begin
               if (wr_csr) begin
                  in_ena_reg  <= wd[31];
                  in_ie_reg   <= wd[26];
                  out_ena_reg <= wd[15];
                  out_ie_reg  <= wd[10];
               end
               // A new event in the same cycle as its W1C keeps the flag set.
               in_ovr_reg  <= ovr_set | (in_ovr_reg  & ~(wr_csr & wd[27]));
               out_und_reg <= und_set | (out_und_reg & ~(wr_csr & wd[11]));
               if (wr_thr) begin
                  in_thr_reg  <= wd[24:16];
                  out_thr_reg <= wd[8:0];
               end
            end
         end

         assign in_lvl9  = 9'(in_lvl_reg);
         assign out_lvl9 = 9'(out_lvl_reg);

         assign ch_src[gi] = (in_ie_reg  & (in_lvl9  >= in_thr_reg))
                           | (out_ie_reg & (out_lvl9 <= out_thr_reg))
                           | in_ovr_reg | out_und_reg;
         assign ch_in_empty[gi] = in_empty;
         assign pcm_out_data[16*gi +: 16] = (out_ena_reg & ~out_empty) ? out_head : 16'h0;

         always_comb begin
            ch_rdata[gi] = 32'h0;
            case (bus_reg)
               2'd0: ch_rdata[gi] = {in_ena_reg, 1'b0, in_full, in_empty, in_ovr_reg,
                                     in_ie_reg, 1'b0, in_lvl9,
                                     out_ena_reg, 1'b0, out_full, out_empty, out_und_reg,
                                     out_ie_reg, 1'b0, out_lvl9};
               2'd1: ch_rdata[gi] = {7'h0, in_thr_reg, 7'h0, out_thr_reg};
               2'd2: ch_rdata[gi] = {in_empty, 15'h0, in_empty ? 16'h0 : in_head};
               default: ch_rdata[gi] = 32'h0;
            endcase
         end
      end else begin : g_none
         assign ch_rdata[gi]    = 32'h0;
         assign ch_in_empty[gi] = 1'b1;
         assign ch_src[gi]      = 1'b0;
      end
   end
endmodule

// File: tb/tb_mc97_pcm_wb.sv
// Directed bench for mc97_pcm_wb with FIFO_AW=2 (4-deep FIFOs) and two channels.
module tb_mc97_pcm_wb;
   localparam int N_CH    = 2;
   localparam int FIFO_AW = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mc97_pcm_wb_if bus ();
   logic [16*N_CH-1:0] pcm_in_data;
   logic [N_CH-1:0]    pcm_in_stb;
   logic [16*N_CH-1:0] pcm_out_data;
   logic [N_CH-1:0]    pcm_out_ack;
   logic               irq;

   mc97_pcm_wb #(.N_CH(N_CH), .FIFO_AW(FIFO_AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .wb           (bus),
      .pcm_in_data  (pcm_in_data),
      .pcm_in_stb   (pcm_in_stb),
      .pcm_out_data (pcm_out_data),
      .pcm_out_ack  (pcm_out_ack),
      .irq          (irq)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic        we;
      logic [3:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // side: 0 none, 1 capture strobe on ch, 2 playback ack on ch -- both land on the effect edge
   task automatic bus_xfer(input logic we, input logic [3:0] a, input logic [31:0] d,
                           input int side, input int ch, input logic [15:0] sd,
                           output logic [31:0] rd);
      int n;
      @(negedge clk);
      bus.wb_cyc = 1'b1; bus.wb_we = we; bus.wb_addr = a; bus.wb_wdata = d;
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!bus.wb_ack && n < 8);
      check("ack_latency", 32'(n), 32'd1);
      rd = bus.wb_rdata;
      if (side == 1) begin
         pcm_in_data[16*ch +: 16] = sd;
         pcm_in_stb[ch] = 1'b1;
      end else if (side == 2) begin
         pcm_out_ack[ch] = 1'b1;
      end
      @(posedge clk); #1;
      bus.wb_cyc = 1'b0; bus.wb_we = 1'b0;
      pcm_in_stb = '0; pcm_out_ack = '0;
      $display("xfer %s addr=0x%h wdata=0x%08h rdata=0x%08h", we ? "W" : "R", a, d, rd);
   endtask

   task automatic rd_chk(input logic [3:0] a, input logic [31:0] exp, input string name);
      logic [31:0] r;
      bus_xfer(1'b0, a, 32'h0, 0, 0, 16'h0, r);
      check(name, r, exp);
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      logic [31:0] r;
      bus_xfer(1'b1, a, d, 0, 0, 16'h0, r);
      check("wr_rdata_zero", r, 32'h0);
   endtask

   task automatic pulse_in(input int ch, input logic [15:0] d);
      @(negedge clk);
      pcm_in_data[16*ch +: 16] = d;
      pcm_in_stb[ch] = 1'b1;
      @(posedge clk); #1;
      pcm_in_stb = '0;
   endtask

   task automatic pulse_out(input int ch);
      @(negedge clk);
      pcm_out_ack[ch] = 1'b1;
      @(posedge clk); #1;
      pcm_out_ack = '0;
   endtask

   initial begin
      logic [31:0] r;

      tbl[0]  = '{1'b0, 4'h0, 32'h0,          32'h10001000};
      tbl[1]  = '{1'b0, 4'h1, 32'h0,          32'h00020002};
      tbl[2]  = '{1'b0, 4'h5, 32'h0,          32'h00020002};
      tbl[3]  = '{1'b1, 4'h1, 32'h00030001,   32'h0};
      tbl[4]  = '{1'b0, 4'h1, 32'h0,          32'h00030001};
      tbl[5]  = '{1'b1, 4'h1, 32'h00020002,   32'h0};
      tbl[6]  = '{1'b0, 4'hC, 32'h0,          32'h0};
      tbl[7]  = '{1'b1, 4'hD, 32'hFFFFFFFF,   32'h0};
      tbl[8]  = '{1'b0, 4'h2, 32'h0,          32'h80000000};
      tbl[9]  = '{1'b0, 4'h3, 32'h0,          32'h0};
      tbl[10] = '{1'b1, 4'h0, 32'h00008000,   32'h0};
      tbl[11] = '{1'b0, 4'h0, 32'h0,          32'h10009000};

      bus.wb_cyc = 1'b0; bus.wb_we = 1'b0; bus.wb_addr = '0; bus.wb_wdata = '0;
      pcm_in_data = '0; pcm_in_stb = '0; pcm_out_ack = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ack",   32'(bus.wb_ack), 32'h0);
      check("rst_rdata", bus.wb_rdata, 32'h0);
      check("rst_irq",   32'(irq), 32'h0);
      check("rst_pcm_out", pcm_out_data, 32'h0);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         bus_xfer(tbl[i].we, tbl[i].addr, tbl[i].wdata, 0, 0, 16'h0, r);
         check($sformatf("vec%0d", i), r, tbl[i].exp);
      end

      // Playback: two pushes, drain, then underrun
      wr(4'h3, 32'h00001111);
      wr(4'h3, 32'h00002222);
      rd_chk(4'h0, 32'h10008002, "out_lvl2");
      check("pcm_out_head0", pcm_out_data[15:0], 32'h1111);
      pulse_out(0);
      check("pcm_out_head1", pcm_out_data[15:0], 32'h2222);
      pulse_out(0);
      check("pcm_out_empty", pcm_out_data[15:0], 32'h0);
      pulse_out(0);
      rd_chk(4'h0, 32'h10009800, "out_und_set");
      check("irq_und", 32'(irq), 32'h1);

      // W1C of out_und together with a fresh underrun: set wins
      bus_xfer(1'b1, 4'h0, 32'h00008800, 2, 0, 16'h0, r);
      rd_chk(4'h0, 32'h10009800, "und_set_wins");
      wr(4'h0, 32'h00008800);
      rd_chk(4'h0, 32'h10009000, "und_cleared");
      check("irq_clear", 32'(irq), 32'h0);

      // Playback FIFO overfill drops silently, then flush
      for (int i = 1; i <= 5; i++) wr(4'h3, 32'(i));
      rd_chk(4'h0, 32'h1000A004, "out_full");
      check("pcm_out_full_head", pcm_out_data[15:0], 32'h0001);
      wr(4'h0, 32'h0000C000);
      rd_chk(4'h0, 32'h10009000, "out_flush");

      // Capture on ch1: overflow, drain in order, then empty marker
      wr(4'h4, 32'h80000000);
      for (int i = 0; i < 5; i++) pulse_in(1, 16'h00A0 + 16'(i));
      rd_chk(4'h4, 32'hA8041000, "in_full_ovr");
      check("irq_ovr", 32'(irq), 32'h1);
      for (int i = 0; i < 4; i++) rd_chk(4'h6, 32'h000000A0 + 32'(i), $sformatf("in_pop%0d", i));
      rd_chk(4'h6, 32'h80000000, "in_empty_read");
      wr(4'h4, 32'h88000000);
      rd_chk(4'h4, 32'h90001000, "ovr_cleared");

      // Level interrupt on ch0 capture, threshold 2
      check("irq_idle", 32'(irq), 32'h0);
      wr(4'h0, 32'h84008000);
      pulse_in(0, 16'h0B01);
      pulse_in(0, 16'h0B02);
      check("irq_lat_before", 32'(irq), 32'h0);
      @(posedge clk); #1;
      check("irq_lat_after", 32'(irq), 32'h1);
      rd_chk(4'h2, 32'h00000B01, "thr_pop");
      check("irq_hold", 32'(irq), 32'h1);
      @(posedge clk); #1;
      check("irq_drop", 32'(irq), 32'h0);

      // Concurrent capture push and bus pop at level 2
      pulse_in(0, 16'h0B03);
      bus_xfer(1'b0, 4'h2, 32'h0, 1, 0, 16'h0B04, r);
      check("pushpop_data", r, 32'h00000B02);
      rd_chk(4'h0, 32'h84029000, "pushpop_lvl");
      rd_chk(4'h2, 32'h00000B03, "order0");
      rd_chk(4'h2, 32'h00000B04, "order1");

      // Flush beats a concurrent capture push
      pulse_in(0, 16'h0B05);
      bus_xfer(1'b1, 4'h0, 32'hC4008000, 1, 0, 16'h0B06, r);
      rd_chk(4'h0, 32'h94009000, "flush_wins");
      rd_chk(4'h2, 32'h80000000, "flush_empty");

      // Reset during an ack cycle drops the transaction
      @(negedge clk);
      bus.wb_cyc = 1'b1; bus.wb_we = 1'b1; bus.wb_addr = 4'h3; bus.wb_wdata = 32'h5555;
      @(posedge clk); #1;
      check("midrst_ack1", 32'(bus.wb_ack), 32'h1);
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_ack0", 32'(bus.wb_ack), 32'h0);
      rst = 1'b0; bus.wb_cyc = 1'b0; bus.wb_we = 1'b0;
      rd_chk(4'h0, 32'h10001000, "midrst_csr");
      check("midrst_pcm_out", pcm_out_data, 32'h0);
      check("midrst_irq", 32'(irq), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/mc97_pcm_wb.md
MC97_PCM_WB -- requirements
Module: mc97_pcm_wb

Interface
REQ-001 Parameter N_CH, default 2, number of independent PCM channels (legal 1..4).
REQ-002 Parameter FIFO_AW, default 8; each per-channel FIFO holds 2^FIFO_AW 16-bit words (legal 2..8).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  sole clock, all logic on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 wb_addr  in  4  [3:2] channel, [1:0] register.
REQ-007 wb_wdata  in  32  write data.
REQ-008 wb_rdata  out  32  read data, registered.
REQ-009 wb_we  in  1  write qualifier.
REQ-010 wb_cyc  in  1  cycle request.
REQ-011 wb_ack  out  1  cycle acknowledge.
REQ-012 pcm_in_data  in  16*N_CH  capture sample per channel (ch k at [16k+15:16k]).
REQ-013 pcm_in_stb  in  N_CH  capture sample valid, one cycle.
REQ-014 pcm_out_data  out  16*N_CH  playback sample per channel.
REQ-015 pcm_out_ack  in  N_CH  playback sample consumed, one cycle.
REQ-016 irq  out  1  registered interrupt, OR of all channel sources.

Function
REQ-017 Bus: wb_ack SHALL be 1 exactly one cycle after wb_cyc rises (ack <= cyc & ~ack); wb_rdata valid in ack cycle, 0 otherwise or on writes.
REQ-018 Write/read side effects SHALL be applied at the end of the ack cycle (visible the following cycle); exactly one effect per transaction.
REQ-019 Register 0 (CSR) in bits: 31 in_ena RW, 30 in_flush W (reads 0), 29 in_full RO, 28 in_empty RO, 27 in_ovr W1C, 26 in_ie RW, [24:16] in_lvl RO zero-extended.
REQ-020 Register 0 out bits: 15 out_ena, 14 out_flush, 13 out_full, 12 out_empty, 11 out_und W1C, 10 out_ie, [8:0] out_lvl; same semantics as REQ-019.
REQ-021 Register 1 (THR): [24:16] in_thr RW, [8:0] out_thr RW; other bits read 0.
REQ-022 Register 2 (IN_DATA) read SHALL return {in_empty, 15'h0, head}, then pop one word only if not empty; when empty returns 0x80000000, no pop; writes ignored.
REQ-023 Register 3 (OUT_DATA) write SHALL push wb_wdata[15:0] if out FIFO not full, else drop silently; reads return 0.
REQ-024 Channel index >= N_CH: reads return 0, writes no effect, ack still generated.
REQ-025 Capture: pcm_in_stb[k] with in_ena SHALL push pcm_in_data[k] if not full; if full, sample dropped and in_ovr set; ignored when in_ena=0.
REQ-026 Playback: pcm_out_data[k] SHALL equal out FIFO head when out_ena=1 and not empty, else 0 (combinational from FIFO state).
REQ-027 pcm_out_ack[k] with out_ena SHALL pop if not empty; if empty, out_und set, no pop; ignored when out_ena=0.
REQ-028 Simultaneous push and pop on one FIFO: both occur, level unchanged; push on full refused even with concurrent pop; pop on empty refused even with concurrent push (no bypass).
REQ-029 Flush write SHALL reset that FIFO to empty (level 0) at end of ack cycle; flush wins over a same-cycle push or pop.
REQ-030 Sticky flag set and W1C clear in same cycle: set wins.
REQ-031 Channel source = (in_ie & in_lvl >= in_thr) | (out_ie & out_lvl <= out_thr) | in_ovr | out_und; irq SHALL be registered OR of all channel sources (1-cycle latency).
REQ-032 Levels are FIFO_AW+1 bits, range 0..2^FIFO_AW; full when level = 2^FIFO_AW; pointers wrap modulo 2^FIFO_AW.
REQ-033 Channels are independent; no cross-channel ordering or arbitration.

Reset
REQ-034 On rst: wb_ack=0, wb_rdata=0, irq=0, all FIFOs empty, ena/ie/ovr/und=0.
REQ-035 On rst: in_thr=out_thr=2^(FIFO_AW-1); pcm_out_data all 0.
REQ-036 rst mid-transaction SHALL drop the transaction with no side effect; wb_ack=0 next cycle.

Verification
REQ-037 FIFO_AW=2, ch0 out_ena=1: write 0x1111,0x2222 to addr 0x3 -> out_lvl=2, pcm_out_data[15:0]=0x1111; ack pulse -> 0x2222; two more acks -> 0, out_und=1.
REQ-038 ch1 in_ena=1, FIFO_AW=2: 5 stb with 0xA0..0xA4 -> in_lvl=4, in_full=1, in_ovr=1; reads of addr 0x6 return 0xA0..0xA3, then 0x80000000.
REQ-039 ch0 in_ie=1, in_thr=2: two stb -> irq=1 cycle after second push; one bus read -> irq=0 cycle after pop.
REQ-040 Same cycle pcm_in_stb and IN_DATA pop at level 2 -> level 2, order preserved; flush write with concurrent stb -> level 0.
REQ-041 W1C of out_und coinciding with new underrun -> out_und remains 1; N_CH=2 read of addr 0xC -> 0.
